fp_divider_iter: RTL

- Sequential IEEE-754 single-precision divider; inverse companion to the team's combinational fp_multiplier_32bit.
- Computes quotient = a / b using a radix-2 restoring mantissa divider, one quotient bit per cycle.
- Valid/ready handshake on input and output; sits in the same arithmetic datapath as the multiplier.
- Denormal inputs flush to zero; results truncate by default (same as the multiplier), with optional round-to-nearest-even.

---
 rtl/fp_divider_iter.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/fp_divider_iter.sv
// Iterative IEEE-754 single-precision divider: radix-2 restoring mantissa division, one quotient bit per cycle.
// Define FP_DIV_ROUND_EN for round-to-nearest-even; the default build truncates.
module fp_divider_iter #(
  parameter int WIDTH = 32,
  parameter int ITER  = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic             div_by_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_NORM = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [4:0] LAST = 5'(ITER - 1);

  logic [1:0]        state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [24:0]       rem_q, rem_d;
  logic [25:0]       q_q, q_d;
  logic [23:0]       mb_q, mb_d;
  logic signed [9:0] exp_q, exp_d;
  logic              sign_q, sign_d;
  logic [22:0]       mant_q, mant_d;
  logic              guard_q, guard_d;
  logic              sticky_q, sticky_d;
  logic [31:0]       quot_q, quot_d;
  logic              dbz_q, dbz_d;

  logic       zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, sign_ab;
  logic       ge;
  logic [24:0] diff;
  logic [23:0] mant_r;
  logic signed [9:0] exp_r;
  logic       inc;

  assign zero_a  = (a[30:23] == 8'h00);
  assign zero_b  = (b[30:23] == 8'h00);
  assign inf_a   = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
  assign inf_b   = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
  assign nan_a   = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
  assign nan_b   = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
  assign sign_ab = a[31] ^ b[31];

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign quotient    = quot_q;
  assign div_by_zero = dbz_q;

`ifdef FP_DIV_ROUND_EN
  assign inc = guard_q & (sticky_q | mant_q[0]);
`else
  logic unused_rnd;
  assign inc        = 1'b0;
  assign unused_rnd = guard_q | sticky_q;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    q_d      = q_q;
    mb_d     = mb_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    mant_d   = mant_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    quot_d   = quot_q;
    dbz_d    = dbz_q;
    ge       = (rem_q >= {1'b0, mb_q});
    diff     = ge ? (rem_q - {1'b0, mb_q}) : rem_q;
    mant_r   = {1'b0, mant_q} + {23'h0, inc};
    exp_r    = exp_q + $signed({9'h0, mant_r[23]});

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d = sign_ab;
          if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) begin
            quot_d  = 32'h7FC0_0000;
            state_d = S_DONE;
          end else if (inf_a) begin
            quot_d  = {sign_ab, 8'hFF, 23'h0};
            state_d = S_DONE;
          end else if (inf_b) begin
            quot_d  = {sign_ab, 31'h0};
            state_d = S_DONE;
          end else if (zero_b) begin
            quot_d  = {sign_ab, 8'hFF, 23'h0};
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else if (zero_a) begin
            quot_d  = {sign_ab, 31'h0};
            state_d = S_DONE;
          end else begin
            rem_d   = {2'b01, a[22:0]};
            mb_d    = {1'b1, b[22:0]};
            exp_d   = $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]}) + 10'sd127;
            q_d     = '0;
            cnt_d   = '0;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        rem_d = diff << 1;
        q_d   = {q_q[24:0], ge};
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = S_NORM;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_NORM: begin
        // Two sub-steps keyed on cnt_q: normalise, then round/range-check/pack.
        if (cnt_q == 5'd0) begin
          if (q_q[25]) begin
            mant_d   = q_q[24:2];
            guard_d  = q_q[1];
            sticky_d = q_q[0] | (rem_q != '0);
          end else begin
            mant_d   = q_q[23:1];
            guard_d  = q_q[0];
            sticky_d = (rem_q != '0);
            exp_d    = exp_q - 10'sd1;
          end
          cnt_d = 5'd1;
        end else begin
          if (exp_r <= 10'sd0)
            quot_d = {sign_q, 31'h0};
          else if (exp_r >= 10'sd255)
            quot_d = {sign_q, 8'hFF, 23'h0};
          else
            quot_d = {sign_q, exp_r[7:0], mant_r[22:0]};
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          dbz_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      q_q      <= '0;
      mb_q     <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      mant_q   <= '0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      quot_q   <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      q_q      <= q_d;
      mb_q     <= mb_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      mant_q   <= mant_d;
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
      quot_q   <= quot_d;
      dbz_q    <= dbz_d;
    end
  end

endmodule
